// File: rtl/n64adv_vpll_ctrl.sv
// Video PLL handover sequencer: enables the PLL, qualifies lock, swaps VCLK_select to 75 MHz, retries and flags failure.
// Optional lock-loss watchdog in RUN: define N64ADV_VPLL_WATCHDOG_EN.
module n64adv_vpll_ctrl #(
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65535,
  parameter int unsigned SWITCH_GUARD_CYC = 32,
  parameter int unsigned MAX_RETRIES      = 3
) (
  input  logic       VCLK,
  input  logic       nVRST,
  input  logic [1:0] LineMult,
  input  logic       VCLK_PLL_LOCKED,
  output logic [1:0] MANAGE_VPLL,
  output logic [1:0] VCLK_select,
  output logic       VPLL_ACTIVE,
  output logic       VPLL_FAIL
);

  localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYC + 1);
  localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int unsigned GRD_W = $clog2(SWITCH_GUARD_CYC + 1);
  localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    ST_DIRECT, ST_WAIT_LOCK, ST_PLL_OFF, ST_ARM, ST_RUN, ST_LEAVE, ST_FAIL
  } state_t;

  state_t state, state_nxt;

  logic [1:0]       lm_r;
  logic             lock_meta, lock_s;
  logic [STB_W-1:0] stable_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [GRD_W-1:0] guard_cnt;
  logic [RTY_W-1:0] retry_cnt;
  logic             guard_done, tmo_done, stable_done, wd_trip;
  logic [1:0]       mng_nxt;
  logic             sel1_nxt, active_nxt, fail_nxt;

  assign guard_done  = (guard_cnt == GRD_W'(SWITCH_GUARD_CYC - 1));
  assign tmo_done    = (tmo_cnt == TMO_W'(LOCK_TIMEOUT_CYC - 1));
  assign stable_done = (stable_cnt == STB_W'(LOCK_STABLE_CYC));

  always_ff @(posedge VCLK) begin
    if (!nVRST) begin
      lm_r <= '0;
    end else begin
      lm_r <= LineMult;
    end
  end

  // Lock reported while the PLL is held in areset is meaningless, so the synchronizer is flushed then.
  always_ff @(posedge VCLK) begin
    if (!nVRST || MANAGE_VPLL == 2'b00) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= VCLK_PLL_LOCKED;
      lock_s    <= lock_meta;
    end
  end

`ifdef N64ADV_VPLL_WATCHDOG_EN
  logic [2:0] wd_cnt;

  assign wd_trip = (wd_cnt == 3'd3) && !lock_s;

  always_ff @(posedge VCLK) begin
    if (!nVRST || state != ST_RUN || lock_s) begin
      wd_cnt <= '0;
    end else if (wd_cnt != 3'd4) begin
      wd_cnt <= wd_cnt + 3'd1;
    end
  end
`else
  assign wd_trip = 1'b0;
`endif

  always_ff @(posedge VCLK) begin
    if (!nVRST) begin
      state <= ST_DIRECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_DIRECT:    if (lm_r[1]) state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (!lm_r[1])         state_nxt = ST_DIRECT;
        else if (stable_done) state_nxt = ST_ARM;
        else if (tmo_done)    state_nxt = (retry_cnt < RTY_W'(MAX_RETRIES)) ? ST_PLL_OFF : ST_FAIL;
      end
      ST_PLL_OFF:   if (guard_done) state_nxt = lm_r[1] ? ST_WAIT_LOCK : ST_DIRECT;
      ST_ARM:       if (guard_done) state_nxt = lm_r[1] ? ST_RUN : ST_DIRECT;
      ST_RUN:       if (!lm_r[1] || wd_trip) state_nxt = ST_LEAVE;
      ST_LEAVE:     if (guard_done) state_nxt = lm_r[1] ? ST_PLL_OFF : ST_DIRECT;
      ST_FAIL:      if (!lm_r[1]) state_nxt = ST_DIRECT;
      default:      state_nxt = ST_DIRECT;
    endcase
  end

  // All per-state counters restart on every state change; each saturates at its own limit.
  always_ff @(posedge VCLK) begin
    if (!nVRST) begin
      stable_cnt <= '0;
      tmo_cnt    <= '0;
      guard_cnt  <= '0;
    end else if (state_nxt != state) begin
      stable_cnt <= '0;
      tmo_cnt    <= '0;
      guard_cnt  <= '0;
    end else begin
      if (state != ST_WAIT_LOCK || !lock_s)
        stable_cnt <= '0;
      else if (!stable_done)
        stable_cnt <= stable_cnt + STB_W'(1);
      if (tmo_cnt != TMO_W'(LOCK_TIMEOUT_CYC))
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (guard_cnt != GRD_W'(SWITCH_GUARD_CYC))
        guard_cnt <= guard_cnt + GRD_W'(1);
    end
  end

  always_ff @(posedge VCLK) begin
    if (!nVRST || state == ST_DIRECT || (state != ST_RUN && state_nxt == ST_RUN)) begin
      retry_cnt <= '0;
    end else if (state == ST_PLL_OFF && state_nxt == ST_WAIT_LOCK &&
                 retry_cnt != RTY_W'(MAX_RETRIES)) begin
      retry_cnt <= retry_cnt + RTY_W'(1);
    end
  end

  // Outputs are decoded from the next state so they land on the same edge as the state change.
  always_comb begin
    mng_nxt    = 2'b00;
    sel1_nxt   = 1'b0;
    active_nxt = 1'b0;
    fail_nxt   = 1'b0;
    unique case (state_nxt)
      ST_WAIT_LOCK: mng_nxt = 2'b01;
      ST_ARM:       mng_nxt = 2'b10;
      ST_RUN: begin
        mng_nxt    = 2'b10;
        sel1_nxt   = 1'b1;
        active_nxt = 1'b1;
      end
      ST_LEAVE:     mng_nxt = 2'b10;
      ST_FAIL:      fail_nxt = 1'b1;
      default:      mng_nxt = 2'b00;
    endcase
  end

  always_ff @(posedge VCLK) begin
    if (!nVRST) begin
      MANAGE_VPLL <= '0;
      VCLK_select <= '0;
      VPLL_ACTIVE <= 1'b0;
      VPLL_FAIL   <= 1'b0;
    end else begin
      MANAGE_VPLL <= mng_nxt;
      VCLK_select <= {sel1_nxt, lm_r[0]};
      VPLL_ACTIVE <= active_nxt;
      VPLL_FAIL   <= fail_nxt;
    end
  end

endmodule
